// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: circular FIFO between the i-cache and decode,
// with redirect flush and a registered flag for non-sequential pushes.
module fetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [ADDR_WIDTH-1:0]        i_pc,
  input  logic [DATA_WIDTH-1:0]        i_instr,
  output logic                         o_in_ready,
  output logic                         o_valid,
  output logic [ADDR_WIDTH-1:0]        o_pc,
  output logic [DATA_WIDTH-1:0]        o_instr,
  input  logic                         i_ready,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_seq_break
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_WIDTH-1:0] pc_mem_r    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [ADDR_WIDTH-1:0] last_pc_r;
  logic                  last_pc_valid_r;
  logic                  seq_break_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  break_s;

  assign full_s     = (count_r == CNT_W'(DEPTH));
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign o_in_ready = ~full_s & ~i_flush;
  assign push_s     = i_valid & o_in_ready;
  assign pop_s      = ~empty_s & i_ready;

  assign o_valid     = ~empty_s;
  assign o_count     = count_r;
  assign o_pc        = pc_mem_r[rd_ptr_r];
  assign o_instr     = instr_mem_r[rd_ptr_r];
  assign o_seq_break = seq_break_r;

  // Sequence-break detection against the previously accepted PC
  always_comb begin
    break_s = 1'b0;
    if (push_s && last_pc_valid_r) begin
      break_s = (i_pc != (last_pc_r + ADDR_WIDTH'(32'd4)));
    end else begin
      break_s = 1'b0;
    end
  end

  // Entry storage: written on accepted push, never reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= i_pc;
      instr_mem_r[wr_ptr_r] <= i_instr;
    end
  end

  // Pointers, occupancy and PC-tracking state; flush wins over push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      last_pc_r       <= {ADDR_WIDTH{1'b0}};
      last_pc_valid_r <= 1'b0;
      seq_break_r     <= 1'b0;
    end else if (i_flush) begin
      wr_ptr_r        <= {PTR_W{1'b0}};
      rd_ptr_r        <= {PTR_W{1'b0}};
      count_r         <= {CNT_W{1'b0}};
      last_pc_valid_r <= 1'b0;
      seq_break_r     <= 1'b0;
    end else begin
      seq_break_r <= break_s;
      if (push_s) begin
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
        last_pc_r       <= i_pc;
        last_pc_valid_r <= 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4, 26-bit PC).
module tb_fetch_buffer;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [25:0] i_pc;
  logic [31:0] i_instr;
  logic        o_in_ready;
  logic        o_valid;
  logic [25:0] o_pc;
  logic [31:0] o_instr;
  logic        i_ready;
  logic        i_flush;
  logic [2:0]  o_count;
  logic        o_seq_break;

  int checks;
  int failures;

  fetch_buffer #(.DEPTH(4), .ADDR_WIDTH(26), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
    .o_in_ready(o_in_ready), .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
    .i_ready(i_ready), .i_flush(i_flush), .o_count(o_count), .o_seq_break(o_seq_break)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [25:0] pc);
    i_valid = 1'b1;
    i_pc    = pc;
    i_instr = {6'd0, pc} ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_valid = 1'b0; i_pc = 26'd0; i_instr = 32'd0;
    i_ready = 1'b0; i_flush = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL reset_seq_break got=%b exp=0", o_seq_break); end
  endtask

  task automatic test_push_basic;
    drive_push(26'h100); tick;
    checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL push1_valid got=%b exp=1", o_valid); end
    checks++; if (o_pc !== 26'h100) begin failures++; $display("FAIL push1_pc got=%h exp=100", o_pc); end
    checks++; if (o_instr !== 32'hA5A5_0100) begin failures++; $display("FAIL push1_instr got=%h exp=a5a50100", o_instr); end
    drive_push(26'h104); tick;
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL push2_seq_break got=%b exp=0", o_seq_break); end
    drive_push(26'h108); tick;
    checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL push3_count got=%0d exp=3", o_count); end
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL push3_seq_break got=%b exp=0", o_seq_break); end
    checks++; if (o_pc !== 26'h100) begin failures++; $display("FAIL push3_head got=%h exp=100", o_pc); end
  endtask

  task automatic test_full;
    drive_push(26'h10C); tick;
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", o_count); end
    drive_push(26'h200); #1;
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", o_in_ready); end
    tick;
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL full_drop_count got=%0d exp=4", o_count); end
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL full_drop_seq got=%b exp=0", o_seq_break); end
  endtask

  task automatic test_full_pop;
    logic [25:0] exp_pc [4];
    exp_pc[0] = 26'h104; exp_pc[1] = 26'h108; exp_pc[2] = 26'h10C; exp_pc[3] = 26'h110;
    drive_push(26'h110); i_ready = 1'b1; tick;
    checks++; if (o_count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d exp=3", o_count); end
    checks++; if (o_pc !== 26'h104) begin failures++; $display("FAIL fullpop_head got=%h exp=104", o_pc); end
    i_ready = 1'b0; tick;
    checks++; if (o_count !== 3'd4) begin failures++; $display("FAIL fullpop_repush got=%0d exp=4", o_count); end
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL fullpop_seq got=%b exp=0", o_seq_break); end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_pc !== exp_pc[k]) begin failures++; $display("FAIL drain_pc%0d got=%h exp=%h", k, o_pc, exp_pc[k]); end
      tick;
    end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b exp=0", o_valid); end
    tick;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL underflow_count got=%0d exp=0", o_count); end
    i_ready = 1'b0;
  endtask

  task automatic test_seq_break;
    i_flush = 1'b1; tick; i_flush = 1'b0;
    drive_push(26'h100); tick;
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL sb_first got=%b exp=0", o_seq_break); end
    drive_push(26'h180); tick;
    checks++; if (o_seq_break !== 1'b1) begin failures++; $display("FAIL sb_pulse got=%b exp=1", o_seq_break); end
    i_valid = 1'b0; tick;
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL sb_clear got=%b exp=0", o_seq_break); end
    checks++; if (o_count !== 3'd2) begin failures++; $display("FAIL sb_count got=%0d exp=2", o_count); end
  endtask

  task automatic test_flush;
    drive_push(26'h184); i_flush = 1'b1; #1;
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", o_in_ready); end
    tick;
    i_flush = 1'b0; i_valid = 1'b0;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", o_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    drive_push(26'h300); tick;
    checks++; if (o_seq_break !== 1'b0) begin failures++; $display("FAIL flush_seq got=%b exp=0", o_seq_break); end
    checks++; if (o_pc !== 26'h300) begin failures++; $display("FAIL flush_head got=%h exp=300", o_pc); end
    i_valid = 1'b0; i_ready = 1'b1; tick; i_ready = 1'b0;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL flush_pop got=%0d exp=0", o_count); end
  endtask

  task automatic test_wrap;
    logic [25:0] q[$];
    logic        do_push;
    logic        do_pop;
    logic [25:0] pc;
    for (int k = 0; k < 10; k++) begin
      pc = 26'h400 + 26'(4 * k);
      drive_push(pc);
      i_ready = ((k % 3) != 0);
      do_push = (q.size() != 4);
      do_pop  = (q.size() != 0) && i_ready;
      tick;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(pc);
      checks++; if (o_count !== 3'(q.size())) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=%0d", k, o_count, q.size()); end
      if (q.size() != 0) begin
        checks++; if (o_pc !== q[0]) begin failures++; $display("FAIL wrap_pc%0d got=%h exp=%h", k, o_pc, q[0]); end
        checks++; if (o_instr !== ({6'd0, q[0]} ^ 32'hA5A5_0000)) begin failures++; $display("FAIL wrap_instr%0d got=%h", k, o_instr); end
      end
    end
    checks++; if (o_count === 3'd0) begin failures++; $display("FAIL wrap_nonempty got=%0d exp=nonzero", o_count); end
    rst_n = 1'b0; drive_push(26'h500); i_ready = 1'b1; tick;
    checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL midreset_count got=%0d exp=0", o_count); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", o_valid); end
    rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b0; #1;
    checks++; if (o_in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%b exp=1", o_in_ready); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_push_basic;
    test_full;
    test_full_pop;
    test_seq_break;
    test_flush;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
